imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a byte stream (valid/ready),
//  packs little-endian bytes into 32-bit words and drives the IM write port.
//  Sits between the host/UART byte source and InstructionMemory. Holds the core in reset
//  via busy while a program is being loaded.
// PARAMETERS
//  IM_DEPTH   64  number of 32-bit words in instruction memory
//  ADDR_W     6   IM word-address width, clog2(IM_DEPTH)
//  BASE_ADDR  0   first word index written
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-low reset (asserted when 0)
//  start     in   1       one-cycle pulse; begins a load
//  in_valid  in   1       byte-stream valid
//  in_data   in   8       byte-stream data
//  in_ready  out  1       loader accepts a byte this cycle
//  im_we     out  1       IM write strobe, one cycle per word
//  im_waddr  out  ADDR_W  IM word address
//  im_wdata  out  32      IM write data
//  busy      out  1       load in progress; core fetch must be held off
//  done      out  1       sticky; load finished
//  err       out  1       sticky; length overflow (or checksum mismatch)
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE. All outputs 0. Byte lane, word counter and packer cleared.
//  - Byte accepted iff in_valid && in_ready. in_ready=1 only in HDR0, HDR1, DATA, CHK.
//  - FSM: IDLE -start-> HDR0 -byte-> HDR1 -byte-> DATA | DONE; DATA -last word-> DONE
//    (or CHK); CHK -byte-> DONE; DONE -start-> HDR0.
//  - Header: LEN[15:0], little-endian (HDR0 = LEN[7:0], HDR1 = LEN[15:8]), count in words.
//  - Header checks at HDR1 acceptance:
//    - LEN==0 -> DONE, done=1.
//    - LEN > IM_DEPTH-BASE_ADDR -> DONE, err=1, done=1; no data bytes consumed.
//  - DATA: lane 0..3. Byte k of a word lands in wdata[8k+7:8k].
//  - Write timing: on acceptance of lane 3, next cycle im_we=1 for exactly one cycle.
//    im_waddr = BASE_ADDR + word index (0-based); im_wdata = packed word.
//  - Latency: 1 cycle from 4th byte accept to im_we.
//  - Back-to-back words: no bubble required; in_ready stays 1 in DATA during the im_we cycle.
//  - Word counter: 16-bit. Transition out of DATA when counter == LEN after the last accept.
//    Final im_we occurs in the first cycle of DONE/CHK.
//  - busy=1 in every state except IDLE and DONE. done and err are cleared on start.
//  - start while busy: ignored. in_valid outside accepting states: ignored, not consumed.
//  - Address arithmetic: ADDR_W bits. The header check guarantees no wrap; no wrap handling.
//  - Reset mid-load: immediate return to IDLE. IM holds partial contents; no write in flight
//    completes.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined:
//    - after the last data word, state CHK accepts one byte.
//    - If it != XOR of all data bytes (header excluded): err=1. done=1 regardless.
//  - Undefined: no CHK state; DATA goes straight to DONE. err only from length overflow.
// STRUCTURE
//  - Package imem_loader_pkg:
//    - state enum {IDLE,HDR0,HDR1,DATA,CHK,DONE}
//    - WORD_BYTES=4, LEN_W=16
//  - Sub-module imem_byte_packer: lane counter + 32-bit shift/pack register.
//    Outputs word_valid (one cycle) and word.
//  - FSM, header capture, counters and checksum stay in imem_loader.
// TESTING
//  - Reset/idle: hold reset=0 mid-stream -> all outputs 0. Release, no start -> in_ready=0.
//  - Basic load: start; bytes 02 00, 13 00 00 00, 93 00 10 00 ->
//    im_we at addr 0 data 00000013, then addr 1 data 00100093. done=1, busy=0.
//  - Overflow: header 41 00 (65 words, IM_DEPTH=64) -> err=1, done=1, no im_we,
//    in_ready=0 after HDR1.
//  - Zero length: header 00 00 -> done=1 next cycle, no im_we.
//  - Throttling: in_valid toggling 1/0 each cycle over a 3-word load ->
//    words and addresses identical to unthrottled run. im_we count = 3.
//  - Checksum (LOADER_CHECKSUM_EN): 1 word 01 02 03 04, chk 04 -> err=0; chk 05 -> err=1.
//    Reset asserted mid-word -> IDLE, no im_we.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_pkg : shared types and constants for the IM loader        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic is_accepting(input state_t s);
        return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if : byte-stream input and IM write port of the loader   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;

    // master: the loader itself; slave: byte source plus instruction memory
    modport master (
        input  in_valid, in_data,
        output in_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, im_we, im_waddr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_byte_packer : packs little-endian bytes into 32-bit words        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    input  wire logic        byte_valid,
    input  wire logic [7:0]  byte_data,
    output logic             last_lane,
    output logic             word_valid,
    output logic [31:0]      word
);

    logic [LANE_W-1:0]           r_lane;
    logic [8*(WORD_BYTES-1)-1:0] r_shift;
    logic                        r_word_valid;
    logic [31:0]                 r_word;

    // Earlier bytes shift down so byte 0 ends up in the least significant lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane       <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (clear) begin
                r_lane  <= '0;
                r_shift <= '0;
            end else if (byte_valid) begin
                r_shift <= {byte_data, r_shift[8*(WORD_BYTES-1)-1:8]};
                if (last_lane) begin
                    r_word       <= {byte_data, r_shift};
                    r_word_valid <= 1'b1;
                    r_lane       <= '0;
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end
        end
    end

    assign last_lane  = (r_lane == LANE_W'(WORD_BYTES - 1));
    assign word_valid = r_word_valid;
    assign word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : byte-stream program loader driving the IM write port    |
// | Optional trailing checksum byte: define LOADER_CHECKSUM_EN. Rev 1.0   |
// +----------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IM_DEPTH  = 64,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [LEN_W:0] c_max_len = (LEN_W + 1)'(IM_DEPTH - BASE_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_lo;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_done;
    logic              r_err;

    logic              w_ready;
    logic              w_accept;
    logic              w_data_accept;
    logic              w_start;
    logic              w_set_done;
    logic              w_set_err;
    logic              w_last_lane;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [LEN_W-1:0]  w_hdr_len;
    logic [LEN_W-1:0]  w_cnt_next;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    assign w_ready       = is_accepting(r_state);
    assign w_accept      = bus.in_valid && w_ready;
    assign w_data_accept = w_accept && (r_state == DATA);
    assign w_hdr_len     = {bus.in_data, r_len_lo};
    assign w_cnt_next    = r_word_cnt + LEN_W'(1);

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_start),
        .byte_valid (w_data_accept),
        .byte_data  (bus.in_data),
        .last_lane  (w_last_lane),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next  = HDR0;
                    w_start = 1'b1;
                end
            end
            HDR0: begin
                if (w_accept) w_next = HDR1;
            end
            HDR1: begin
                if (w_accept) begin
                    if (w_hdr_len == '0) begin
                        w_next     = DONE;
                        w_set_done = 1'b1;
                    end else if ({1'b0, w_hdr_len} > c_max_len) begin
                        w_next     = DONE;
                        w_set_done = 1'b1;
                        w_set_err  = 1'b1;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept && w_last_lane && (w_cnt_next == r_len)) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = CHK;
`else
                    w_next     = DONE;
                    w_set_done = 1'b1;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (w_accept) begin
                    w_next     = DONE;
                    w_set_done = 1'b1;
                    w_set_err  = (bus.in_data != r_chk);
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_waddr    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_word_cnt <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                if (w_set_done) r_done <= 1'b1;
                if (w_set_err)  r_err  <= 1'b1;
            end
            if (w_accept && (r_state == HDR0)) r_len_lo <= bus.in_data;
            if (w_accept && (r_state == HDR1)) r_len    <= w_hdr_len;
            // Address is latched with the word so it lines up with the packer's strobe.
            if (w_data_accept && w_last_lane) begin
                r_word_cnt <= w_cnt_next;
                r_waddr    <= ADDR_W'(BASE_ADDR) + r_word_cnt[ADDR_W-1:0];
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chk <= '0;
        end else if (w_start) begin
            r_chk <= '0;
        end else if (w_data_accept) begin
            r_chk <= r_chk ^ bus.in_data;
        end
    end
`endif

    assign bus.in_ready = w_ready;
    assign bus.im_we    = w_word_valid;
    assign bus.im_waddr = r_waddr;
    assign bus.im_wdata = w_word;
    assign busy         = (r_state != IDLE) && (r_state != DONE);
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire
